// File: rtl/mcu_spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_spi_pkg
//  Description : Shared constants, flag layout, FSM states and the checksum
//                helper for the MCU SPI frame transmitter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mcu_spi_pkg;

    localparam int         FRAME_BYTES = 17;
    localparam int         FRAME_BITS  = FRAME_BYTES * 8;
    localparam logic [7:0] HEADER_BYTE = 8'hAA;

    // Bit positions inside the flags byte (byte 1)
    localparam int FLAG_QUAT_VALID  = 0;
    localparam int FLAG_GYRO_VALID  = 1;
    localparam int FLAG_INITIALIZED = 2;
    localparam int FLAG_ERROR       = 3;
    localparam int FLAG_SEQ_LSB     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    // XOR of the 16 body bytes; body is packed MSB byte first
    function automatic logic [7:0] frame_checksum(input logic [FRAME_BITS-9:0] body);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < FRAME_BYTES - 1; i++) begin
            acc = acc ^ body[i*8 +: 8];
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pin_sync
//  Description : N-stage pin synchronizer with registered rise/fall pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_last;
    logic              r_rise;
    logic              r_fall;
    logic              w_level;

    assign w_level = r_sync[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RESET_VAL}};
            r_last <= RESET_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync[0] <= pin;
            for (int i = 1; i < STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_last <= w_level;
            r_rise <= w_level & ~r_last;
            r_fall <= ~w_level & r_last;
        end
    end

    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/mcu_spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_spi_frame_tx
//  Description : Read-only SPI mode-0 slave that snapshots the IMU receiver
//                outputs on CS assertion and shifts out a 17-byte frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_spi_frame_tx
    import mcu_spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cs_n,
    input  logic        sck,
    output logic        miso,
    output logic        miso_oe,
    input  logic        initialized,
    input  logic        error,
    input  logic        quat1_valid,
    input  logic        gyro1_valid,
    input  logic [15:0] quat1_w,
    input  logic [15:0] quat1_x,
    input  logic [15:0] quat1_y,
    input  logic [15:0] quat1_z,
    input  logic [15:0] gyro1_x,
    input  logic [15:0] gyro1_y,
    input  logic [15:0] gyro1_z,
    output logic        frame_done,
    output logic        frame_abort,
    output logic [3:0]  seq
);

    localparam logic [7:0] C_FRAME_BITS = 8'(FRAME_BITS);
    localparam logic [4:0] C_PAD_IDX    = 5'(FRAME_BYTES);
    localparam logic [7:0] C_LAST_BYTE0 = 8'(FRAME_BITS - 8);

    logic w_cs_rise;
    logic w_cs_fall;
    logic w_sck_rise;
    logic w_sck_fall;

    spi_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (cs_n),
        .rise  (w_cs_rise),
        .fall  (w_cs_fall)
    );

    spi_pin_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_sck_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pin   (sck),
        .rise  (w_sck_rise),
        .fall  (w_sck_fall)
    );

    state_t                r_state;
    state_t                w_state_nxt;
    logic [FRAME_BITS-1:0] r_frame;
    logic [4:0]            r_byte_idx;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_rise_cnt;
    logic [3:0]            r_seq;
    logic                  r_oe;
    logic [7:0]            w_flags;
    logic [FRAME_BITS-9:0] w_body;
    logic [7:0]            w_bit_pos;

    always_comb begin
        w_flags                      = 8'h00;
        w_flags[FLAG_QUAT_VALID]     = quat1_valid;
        w_flags[FLAG_GYRO_VALID]     = gyro1_valid;
        w_flags[FLAG_INITIALIZED]    = initialized;
        w_flags[FLAG_ERROR]          = error;
        w_flags[FLAG_SEQ_LSB +: 4]   = r_seq;
    end

    assign w_body = {HEADER_BYTE, w_flags, quat1_w, quat1_x, quat1_y, quat1_z,
                     gyro1_x, gyro1_y, gyro1_z};

    always_comb begin
        w_state_nxt = r_state;
        frame_done  = 1'b0;
        frame_abort = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                w_state_nxt = w_cs_rise ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = IDLE;
                    frame_done  = (r_rise_cnt == C_FRAME_BITS);
                    frame_abort = (r_rise_cnt != C_FRAME_BITS);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame    <= '0;
            r_byte_idx <= 5'd0;
            r_bit_idx  <= 3'd7;
            r_rise_cnt <= 8'd0;
            r_seq      <= 4'd0;
            r_oe       <= 1'b0;
        end else begin
            if (w_cs_fall) begin
                r_oe <= 1'b1;
            end else if (w_cs_rise) begin
                r_oe <= 1'b0;
            end

            if (r_state == LOAD) begin
                r_frame    <= {w_body, frame_checksum(w_body)};
                r_byte_idx <= 5'd0;
                r_bit_idx  <= 3'd7;
                r_rise_cnt <= 8'd0;
                r_seq      <= r_seq + 4'd1;
            end else if (r_state == SHIFT && !w_cs_rise) begin
                if (w_sck_rise && r_rise_cnt != C_FRAME_BITS) begin
                    r_rise_cnt <= r_rise_cnt + 8'd1;
                end
                // Falling SCK moves to the next bit; a CS exit in the same cycle suppresses it
                if (w_sck_fall) begin
                    if (r_bit_idx == 3'd0) begin
                        r_bit_idx <= 3'd7;
                        if (r_byte_idx != C_PAD_IDX) begin
                            r_byte_idx <= r_byte_idx + 5'd1;
                        end
                    end else begin
                        r_bit_idx <= r_bit_idx - 3'd1;
                    end
                end
            end
        end
    end

    assign w_bit_pos = C_LAST_BYTE0 - {r_byte_idx, 3'b000} + {5'd0, r_bit_idx};

    // LOAD drives the header MSB directly since the snapshot lands one cycle later
    always_comb begin
        miso = 1'b0;
        case (r_state)
            LOAD:    miso = HEADER_BYTE[7];
            SHIFT:   miso = (r_byte_idx < C_PAD_IDX) ? r_frame[w_bit_pos] : 1'b0;
            default: miso = 1'b0;
        endcase
    end

    assign miso_oe = r_oe;
    assign seq     = r_seq;

endmodule
`default_nettype wire

// File: tb/tb_mcu_spi_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcu_spi_frame_tx
//  Description : Scoreboard bench: an SPI master drives frames while monitors
//                compare MISO bytes and frame events against a frame model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_spi_frame_tx;

    localparam int HALF = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs_n = 1'b1;
    logic        sck = 1'b0;
    logic        miso, miso_oe, frame_done, frame_abort;
    logic        initialized = 1'b0, error = 1'b0, quat1_valid = 1'b0, gyro1_valid = 1'b0;
    logic [15:0] quat1_w = '0, quat1_x = '0, quat1_y = '0, quat1_z = '0;
    logic [15:0] gyro1_x = '0, gyro1_y = '0, gyro1_z = '0;
    logic [3:0]  seq;

    always #5 clk = ~clk;

    mcu_spi_frame_tx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .sck(sck),
        .miso(miso), .miso_oe(miso_oe),
        .initialized(initialized), .error(error),
        .quat1_valid(quat1_valid), .gyro1_valid(gyro1_valid),
        .quat1_w(quat1_w), .quat1_x(quat1_x), .quat1_y(quat1_y), .quat1_z(quat1_z),
        .gyro1_x(gyro1_x), .gyro1_y(gyro1_y), .gyro1_z(gyro1_z),
        .frame_done(frame_done), .frame_abort(frame_abort), .seq(seq)
    );

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_bytes[$];
    logic [1:0] exp_evts[$];   // 2'b10 = done, 2'b01 = abort
    logic [3:0] m_seq = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference frame from the field values, as an MCU would decode it
    function automatic void model_frame(input logic [3:0] s, output logic [7:0] f[17]);
        logic [15:0] w[7];
        w = '{quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z};
        f[0] = 8'hAA;
        f[1] = {s, error, initialized, gyro1_valid, quat1_valid};
        for (int i = 0; i < 7; i++) begin
            f[2 + 2*i] = w[i][15:8];
            f[3 + 2*i] = w[i][7:0];
        end
        f[16] = 8'h00;
        for (int i = 0; i < 16; i++) f[16] = f[16] ^ f[i];
    endfunction

    // MISO byte monitor: samples on SCK rise like a mode-0 master
    logic [7:0] mon_sr = 8'h00;
    int         mon_cnt = 0;
    always @(posedge sck or posedge cs_n) begin
        if (cs_n) begin
            mon_cnt = 0;
        end else begin
            mon_sr = {mon_sr[6:0], miso};
            mon_cnt++;
            if (mon_cnt == 8) begin
                mon_cnt = 0;
                if (exp_bytes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL miso_byte: got %0h expected none at %0t", mon_sr, $time);
                end else begin
                    chk("miso_byte", {24'd0, mon_sr}, {24'd0, exp_bytes.pop_front()});
                end
            end
        end
    end

    // Frame event monitor
    always @(negedge clk) begin
        if (rst_n && (frame_done || frame_abort)) begin
            if (exp_evts.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_event: got %b expected none at %0t", {frame_done, frame_abort}, $time);
            end else begin
                chk("frame_event", {30'd0, frame_done, frame_abort}, {30'd0, exp_evts.pop_front()});
            end
        end
    end

    task automatic run_frame(input int nbytes, input int rst_byte, input bit change_x);
        logic [7:0] f[17];
        int         nexp;
        model_frame(m_seq, f);
        m_seq = m_seq + 4'd1;
        nexp = (rst_byte >= 0) ? rst_byte : nbytes;
        for (int b = 0; b < nexp; b++) exp_bytes.push_back((b < 17) ? f[b] : 8'h00);
        if (rst_byte < 0) exp_evts.push_back((nbytes >= 17) ? 2'b10 : 2'b01);

        cs_n = 1'b0;
        cyc(5);
        chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
        cyc(3);
        for (int b = 0; b < nbytes; b++) begin
            for (int k = 0; k < 8; k++) begin
                if (b == rst_byte && k == 3) begin
                    rst_n = 1'b0;
                    #1;
                    chk("rst_miso", {31'd0, miso}, 32'd0);
                    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
                    chk("rst_seq", {28'd0, seq}, 32'd0);
                    cs_n = 1'b1;
                    sck = 1'b0;
                    m_seq = 4'd0;
                    cyc(3);
                    rst_n = 1'b1;
                    cyc(6);
                    return;
                end
                if (change_x && b == 3 && k == 0) quat1_x = 16'h7FFF;
                sck = 1'b1;
                cyc(HALF);
                sck = 1'b0;
                cyc(HALF);
            end
        end
        cs_n = 1'b1;
        cyc(5);
        chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
        cyc(3);
    endtask

    initial begin
        cyc(2);
        chk("reset_miso", {31'd0, miso}, 32'd0);
        chk("reset_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("reset_seq", {28'd0, seq}, 32'd0);
        chk("reset_events", {30'd0, frame_done, frame_abort}, 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // Directed sample frame
        quat1_w = 16'h4000; quat1_x = 16'h1234; quat1_y = 16'hFF38; quat1_z = 16'h0000;
        gyro1_x = 16'h0001; gyro1_y = 16'h0002; gyro1_z = 16'h0003;
        quat1_valid = 1'b1; gyro1_valid = 1'b1; initialized = 1'b1; error = 1'b0;
        run_frame(17, -1, 1'b0);
        run_frame(17, -1, 1'b0);
        run_frame(17, -1, 1'b0);
        chk("seq_after_three", {28'd0, seq}, {28'd0, m_seq});

        // Mid-frame input change, then the frame that picks it up
        run_frame(17, -1, 1'b1);
        run_frame(17, -1, 1'b0);

        // Short read aborts; next frame restarts at the header
        run_frame(5, -1, 1'b0);
        run_frame(17, -1, 1'b0);

        // Over-long read pads with zeros
        run_frame(20, -1, 1'b0);

        // Reset mid-frame, then a clean frame with seq 0
        run_frame(17, 8, 1'b0);
        run_frame(17, -1, 1'b0);

        // Randomized fields and read lengths; also carries seq through its wrap
        for (int r = 0; r < 17; r++) begin
            quat1_w = 16'($urandom); quat1_x = 16'($urandom);
            quat1_y = 16'($urandom); quat1_z = 16'($urandom);
            gyro1_x = 16'($urandom); gyro1_y = 16'($urandom); gyro1_z = 16'($urandom);
            {error, initialized, gyro1_valid, quat1_valid} = 4'($urandom);
            run_frame((r % 3 == 0) ? 17 : int'($urandom_range(1, 20)), -1, 1'b0);
        end
        chk("seq_after_random", {28'd0, seq}, {28'd0, m_seq});

        cyc(20);
        chk("bytes_drained", exp_bytes.size(), 32'd0);
        chk("events_drained", exp_evts.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
